mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store data access).
- Sits between the pipeline and the memory model; the stage outputs `if_stall` and `dm_stall` feed the pipeline-register hold logic.
- Data port has priority, since the MEM stage holds the older instruction. A streak counter bounds IF starvation.
- A wait timer aborts accesses the memory never acknowledges.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_DM_STREAK, 4, consecutive DM grants allowed while IF waits before IF is forced (legal 1..15).
- TIMEOUT, 16, GRANT-state cycles without `mem_ack` before abort (legal 2..255).

Ports:
- clk, input, 1, system clock, rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- if_req, input, 1, fetch request; level, held until `if_ready`.
- if_addr, input, ADDR_W, fetch address; stable while `if_req`.
- if_rdata, output, DATA_W, fetched instruction.
- if_ready, output, 1, one-cycle completion pulse for IF.
- if_stall, output, 1, `if_req & ~if_ready`.
- dm_req, input, 1, data request; level, held until `dm_ready`.
- dm_we, input, 1, 1 = store, 0 = load.
- dm_addr, input, ADDR_W, data address.
- dm_wdata, input, DATA_W, store data.
- dm_size, input, 2, 00 byte, 01 halfword, 10 word.
- dm_rdata, output, DATA_W, load data.
- dm_ready, output, 1, one-cycle completion pulse for DM.
- dm_stall, output, 1, `dm_req & ~dm_ready`.
- mem_req, output, 1, memory request; held until ack or abort.
- mem_we, output, 1, memory write enable.
- mem_addr, output, ADDR_W, memory address.
- mem_wdata, output, DATA_W, memory write data.
- mem_size, output, 2, access size; IF always 10.
- mem_rdata, input, DATA_W, memory read data; valid when `mem_ack` is high.
- mem_ack, input, 1, memory completion.
- mem_err, output, 1, one-cycle pulse on timeout abort.

Behaviour:
- **Reset.** Asynchronous, active low. Clears every register immediately:
  - state = IDLE;
  - all `mem_*` outputs = 0;
  - `if_rdata` = `dm_rdata` = 0;
  - `if_ready` = `dm_ready` = `mem_err` = 0;
  - streak counter and wait counter = 0.
- **Reset mid-access.** Drops `mem_req` at once; the in-flight transaction is lost and requesters reissue.
- **Outputs.** All outputs except the two stall signals are registered.
- **States:** IDLE, GNT_IF, GNT_DM, DONE.
- **IDLE, arbitration.**
  - dm_req only → GNT_DM.
  - if_req only → GNT_IF.
  - Both high → GNT_DM, unless streak == MAX_DM_STREAK, in which case → GNT_IF.
  - Neither → stay in IDLE.
- **IDLE, on leaving.**
  - Latch the selected address, we, wdata and size into the `mem_*` registers.
  - Set `mem_req` = 1.
  - Clear the wait counter.
- **Streak counter.**
  - Increments on a DM grant only when `if_req` was also high; saturates at MAX_DM_STREAK.
  - Clears on any IF grant, or on a DM grant with `if_req` low.
- **GNT_x states.**
  - `mem_*` outputs are held constant.
  - `mem_ack` sampled high → capture `mem_rdata` into `x_rdata` (IF always; DM only when `dm_we` = 0), drop `mem_req`, assert `x_ready`, go to DONE.
  - Otherwise the wait counter increments.
  - Counter reaches TIMEOUT−1 with no ack → drop `mem_req`, assert `x_ready` and `mem_err`, leave `x_rdata` unchanged, go to DONE.
- **DONE.**
  - `x_ready` (and `mem_err` if aborted) is high for exactly this cycle.
  - No arbitration in DONE; it always returns to IDLE, so a level request is never served twice.
- **Throughput.** Minimum latency is request sampled at edge 0, ack at edge 1, ready during cycle 2. That gives 3 cycles per access with a zero-wait memory.
- **Protocol violations.** `mem_ack` high in IDLE or DONE is ignored. A request dropped before its ready pulse is illegal (undefined, flagged by a bench assertion).
- **Store data.** `dm_rdata` is never modified by a store.
- **Stalls.** `if_stall` and `dm_stall` are combinational from the request inputs and the registered ready outputs.

Decomposition:
- Package `cpu_mem_pkg`:
  - state enum {IDLE, GNT_IF, GNT_DM, DONE};
  - size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - default MAX_DM_STREAK and TIMEOUT values.
- One sub-module, `mem_wait_timer`: a clearable, enabled counter with a terminal-count output at TIMEOUT−1. It holds the timeout logic out of the FSM.

Test Plan:
- **Single IF read.** `if_req`=1, `if_addr`=0x0000_0010; memory acks in the first GNT cycle with 0xE3A0_1005 → `mem_req` high 1 cycle, `if_ready` pulses in cycle 2, `if_rdata`=0xE3A0_1005, `dm_ready` stays 0.
- **Simultaneous requests.** `if_req` and `dm_req` (load 0x40) rise together; memory acks both with 0x1234_5678 → DM is served first, `dm_rdata`=0x1234_5678, then IF is granted; `if_stall` stays high until its `if_ready`.
- **Starvation guard.** `dm_req` held high continuously and `if_req` high, MAX_DM_STREAK=4 → grant order DM, DM, DM, DM, IF, DM…; the streak counter resets after the IF grant.
- **Store.** `dm_we`=1, `dm_addr`=0x80, `dm_wdata`=0xCAFE_F00D, `dm_size`=01 → `mem_we`=1, `mem_size`=01, `mem_wdata` is correct for the whole GNT phase; `dm_rdata` is unchanged after `dm_ready`.
- **Timeout.** `mem_ack` is never asserted, TIMEOUT=16 → `mem_req` falls after 16 GNT cycles, then `dm_ready` and `mem_err` pulse together for one cycle and the FSM returns to IDLE.
- **Reset mid-access.** `rst_n` pulled low during GNT_DM with a wait-state memory → `mem_req` goes to 0 asynchronously, all outputs are 0; after release, a held `dm_req` is re-granted from IDLE.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_IF = 2'd1,
    GNT_DM = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_MAX_DM_STREAK = 4;
  localparam int DEF_TIMEOUT       = 16;
  localparam int STREAK_W          = 4;
  localparam int WAIT_W            = 8;

  // Saturating increment used by the DM streak counter.
  function automatic logic [STREAK_W-1:0] streak_inc(
    input logic [STREAK_W-1:0] cur,
    input logic [STREAK_W-1:0] max
  );
    logic [STREAK_W-1:0] nxt;
    if (cur == max) begin
      nxt = cur;
    end else begin
      nxt = cur + {{(STREAK_W-1){1'b0}}, 1'b1};
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Clearable, enabled wait counter; tc_o flags the last cycle before an abort.
module mem_wait_timer #(
  parameter int TIMEOUT = 16,
  parameter int WAIT_W  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;
  logic              tc_s;

  assign tc_s = (cnt_q == WAIT_W'(TIMEOUT - 1));
  assign tc_o = tc_s;

  // Next count: clear wins, then count up, never past terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {WAIT_W{1'b0}};
    end else if (en_i && !tc_s) begin
      cnt_d = cnt_q + {{(WAIT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WAIT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between instruction fetch and data access;
// data side wins unless IF has been passed over MAX_DM_STREAK times in a row.
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = DEF_MAX_DM_STREAK,
  parameter int TIMEOUT       = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [1:0]        dm_size,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_err
);

  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [1:0]          mem_size_q, mem_size_d;
  logic                mem_err_q, mem_err_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                if_ready_q, if_ready_d;
  logic                dm_ready_q, dm_ready_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                timer_clr_s;
  logic                timer_en_s;
  logic                timer_tc_s;
  logic                dm_wins_s;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .WAIT_W  (WAIT_W)
  ) u_wait_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (timer_clr_s),
    .en_i  (timer_en_s),
    .tc_o  (timer_tc_s)
  );

  // IF is forced only when both request and DM has used up its streak.
  assign dm_wins_s = dm_req && !(if_req && (streak_q == STREAK_MAX));

  // Next-state, memory-side latching and completion logic.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_size_d  = mem_size_q;
    mem_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    streak_d    = streak_q;
    timer_clr_s = 1'b0;
    timer_en_s  = 1'b0;

    case (state_q)
      IDLE: begin
        timer_clr_s = 1'b1;
        if (dm_wins_s) begin
          state_d     = GNT_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          mem_size_d  = dm_size;
          if (if_req) begin
            streak_d = streak_inc(streak_q, STREAK_MAX);
          end else begin
            streak_d = {STREAK_W{1'b0}};
          end
        end else if (if_req) begin
          state_d     = GNT_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = {DATA_W{1'b0}};
          mem_size_d  = SZ_WORD;
          streak_d    = {STREAK_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      GNT_IF, GNT_DM: begin
        if (mem_ack) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (state_q == GNT_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end else begin
            dm_ready_d = 1'b1;
            // Stores complete without touching the load data register.
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end else begin
              dm_rdata_d = dm_rdata_q;
            end
          end
        end else if (timer_tc_s) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_err_d = 1'b1;
          if (state_q == GNT_IF) begin
            if_ready_d = 1'b1;
          end else begin
            dm_ready_d = 1'b1;
          end
        end else begin
          timer_en_s = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops an in-flight request at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      mem_size_q  <= 2'b00;
      mem_err_q   <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      dm_rdata_q  <= {DATA_W{1'b0}};
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      streak_q    <= {STREAK_W{1'b0}};
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_size_q  <= mem_size_d;
      mem_err_q   <= mem_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      streak_q    <= streak_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_size  = mem_size_q;
  assign mem_err   = mem_err_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

  // Stalls stay combinational so the pipeline can hold in the request cycle.
  assign if_stall = if_req & ~if_ready_q;
  assign dm_stall = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a bench-driven memory.
module tb_mem_port_arbiter;
  import cpu_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_rdata;
  logic        if_ready, if_stall;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = 32'h0;
  logic [31:0] dm_wdata = 32'h0;
  logic [1:0]  dm_size = 2'b00;
  logic [31:0] dm_rdata;
  logic        dm_ready, dm_stall;
  logic        mem_req, mem_we, mem_err;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ack;
  logic        ack_en = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  // Zero-wait memory when enabled; acks only while a request is outstanding.
  assign mem_ack = ack_en & mem_req;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_size(dm_size), .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++; if ({mem_req, mem_we, mem_err, if_ready, dm_ready} !== 5'b0) begin tests_failed++; $display("FAIL reset_flags: got %b expected 00000", {mem_req, mem_we, mem_err, if_ready, dm_ready}); end
    tests_run++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata, mem_size} !== 130'b0) begin tests_failed++; $display("FAIL reset_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata, mem_size}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_idle_req: got %b expected 0", mem_req); end
  endtask

  task automatic test_single_if();
    ack_en = 1'b1; mem_rdata = 32'hE3A0_1005;
    if_req = 1'b1; if_addr = 32'h0000_0010;
    tick();
    tests_run++; if ({mem_req, mem_we, mem_size} !== 4'b1010) begin tests_failed++; $display("FAIL if_grant: got %b expected 1010", {mem_req, mem_we, mem_size}); end
    tests_run++; if (mem_addr !== 32'h10) begin tests_failed++; $display("FAIL if_addr: got %h expected 00000010", mem_addr); end
    tests_run++; if (if_stall !== 1'b1) begin tests_failed++; $display("FAIL if_stall_gnt: got %b expected 1", if_stall); end
    tick();
    tests_run++; if ({if_ready, dm_ready, mem_req, if_stall} !== 4'b1000) begin tests_failed++; $display("FAIL if_done: got %b expected 1000", {if_ready, dm_ready, mem_req, if_stall}); end
    tests_run++; if (if_rdata !== 32'hE3A0_1005) begin tests_failed++; $display("FAIL if_rdata: got %h expected e3a01005", if_rdata); end
    if_req = 1'b0;
    tick();
    tests_run++; if ({if_ready, mem_req} !== 2'b00) begin tests_failed++; $display("FAIL if_after: got %b expected 00", {if_ready, mem_req}); end
  endtask

  task automatic test_simultaneous();
    mem_rdata = 32'h1234_5678;
    if_req = 1'b1; if_addr = 32'h14;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40; dm_size = SZ_WORD;
    tick();
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h40}) begin tests_failed++; $display("FAIL sim_dm_first: got %b/%h expected 1/00000040", mem_req, mem_addr); end
    tests_run++; if ({if_stall, dm_stall} !== 2'b11) begin tests_failed++; $display("FAIL sim_stalls: got %b expected 11", {if_stall, dm_stall}); end
    tick();
    tests_run++; if ({dm_ready, if_ready, dm_stall, if_stall} !== 4'b1001) begin tests_failed++; $display("FAIL sim_dm_done: got %b expected 1001", {dm_ready, if_ready, dm_stall, if_stall}); end
    tests_run++; if (dm_rdata !== 32'h1234_5678) begin tests_failed++; $display("FAIL sim_dm_rdata: got %h expected 12345678", dm_rdata); end
    dm_req = 1'b0;
    tick();
    tests_run++; if ({mem_req, if_stall} !== 2'b01) begin tests_failed++; $display("FAIL sim_idle: got %b expected 01", {mem_req, if_stall}); end
    tick();
    tests_run++; if ({mem_req, mem_addr, if_stall} !== {1'b1, 32'h14, 1'b1}) begin tests_failed++; $display("FAIL sim_if_grant: got %b/%h/%b expected 1/00000014/1", mem_req, mem_addr, if_stall); end
    tick();
    tests_run++; if ({if_ready, if_stall, if_rdata} !== {2'b10, 32'h1234_5678}) begin tests_failed++; $display("FAIL sim_if_done: got %b/%b/%h expected 1/0/12345678", if_ready, if_stall, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] got;
    logic       prev;
    int         n;
    logic       done;
    got = 10'b0; prev = 1'b0; n = 0; done = 1'b0;
    mem_rdata = 32'h1111_2222;
    if_addr = 32'h100; dm_addr = 32'h200; dm_we = 1'b0; dm_size = SZ_WORD;
    if_req = 1'b1; dm_req = 1'b1;
    for (int c = 0; c < 120 && !done; c++) begin
      tick();
      if (mem_req && !prev && n < 10) begin
        got[n] = (mem_addr == 32'h200);
        n++;
      end
      prev = mem_req;
      if (n >= 10 && if_ready) if_req = 1'b0;
      if (n >= 10 && !if_req && dm_ready) begin
        dm_req = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) begin if_req = 1'b0; dm_req = 1'b0; end
    tests_run++; if (n !== 10) begin tests_failed++; $display("FAIL starve_count: got %0d grants expected 10", n); end
    // Bit i = 1 means grant i went to DM: D D D D I D D D D I
    tests_run++; if (got !== 10'b0111101111) begin tests_failed++; $display("FAIL starve_order: got %b expected 0111101111", got); end
    tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL starve_drain: got %b expected 1", done); end
    tick(); tick();
  endtask

  task automatic test_store();
    mem_rdata = 32'hDEAD_BEEF; ack_en = 1'b0;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'hCAFE_F00D; dm_size = SZ_HALF;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++; if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata} !== {1'b1, 1'b1, 2'b01, 32'h80, 32'hCAFE_F00D}) begin
        tests_failed++; $display("FAIL store_gnt%0d: got %b%b%b/%h/%h expected 1101/00000080/cafef00d", c, mem_req, mem_we, mem_size, mem_addr, mem_wdata);
      end
    end
    ack_en = 1'b1;
    tick();
    tests_run++; if ({dm_ready, mem_err, mem_req} !== 3'b100) begin tests_failed++; $display("FAIL store_done: got %b expected 100", {dm_ready, mem_err, mem_req}); end
    tests_run++; if (dm_rdata !== 32'h1111_2222) begin tests_failed++; $display("FAIL store_rdata: got %h expected 11112222", dm_rdata); end
    dm_req = 1'b0; dm_we = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int gnt_cycles;
    gnt_cycles = 0;
    ack_en = 1'b0; mem_rdata = 32'h5A5A_5A5A;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44; dm_size = SZ_WORD;
    tick();
    for (int c = 0; c < 40 && mem_req; c++) begin
      gnt_cycles++;
      tests_run++; if ({dm_ready, mem_err} !== 2'b00) begin tests_failed++; $display("FAIL tmo_early_c%0d: got %b expected 00", c, {dm_ready, mem_err}); end
      tick();
    end
    tests_run++; if (gnt_cycles !== 16) begin tests_failed++; $display("FAIL tmo_cycles: got %0d expected 16", gnt_cycles); end
    tests_run++; if ({dm_ready, mem_err, if_ready} !== 3'b110) begin tests_failed++; $display("FAIL tmo_abort: got %b expected 110", {dm_ready, mem_err, if_ready}); end
    tests_run++; if (dm_rdata !== 32'h1111_2222) begin tests_failed++; $display("FAIL tmo_rdata: got %h expected 11112222", dm_rdata); end
    dm_req = 1'b0;
    tick();
    tests_run++; if ({dm_ready, mem_err, mem_req} !== 3'b000) begin tests_failed++; $display("FAIL tmo_after: got %b expected 000", {dm_ready, mem_err, mem_req}); end
    tick();
  endtask

  task automatic test_reset_mid_access();
    ack_en = 1'b0; mem_rdata = 32'h7777_8888;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h48; dm_size = SZ_WORD;
    tick(); tick();
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h48}) begin tests_failed++; $display("FAIL rst_pre: got %b/%h expected 1/00000048", mem_req, mem_addr); end
    rst_n = 1'b0;
    #1;
    tests_run++; if ({mem_req, mem_we, mem_err, if_ready, dm_ready} !== 5'b0) begin tests_failed++; $display("FAIL rst_async_flags: got %b expected 00000", {mem_req, mem_we, mem_err, if_ready, dm_ready}); end
    tests_run++; if ({mem_addr, mem_wdata, if_rdata, dm_rdata, mem_size} !== 130'b0) begin tests_failed++; $display("FAIL rst_async_data: got %h expected 0", {mem_addr, mem_wdata, if_rdata, dm_rdata, mem_size}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++; if ({mem_req, mem_addr} !== {1'b1, 32'h48}) begin tests_failed++; $display("FAIL rst_regrant: got %b/%h expected 1/00000048", mem_req, mem_addr); end
    ack_en = 1'b1;
    tick();
    tests_run++; if ({dm_ready, dm_rdata} !== {1'b1, 32'h7777_8888}) begin tests_failed++; $display("FAIL rst_done: got %b/%h expected 1/77778888", dm_ready, dm_rdata); end
    dm_req = 1'b0;
    tick();
    tests_run++; if (dm_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_after: got %b expected 0", dm_ready); end
  endtask

  initial begin
    test_reset();
    test_single_if();
    test_simultaneous();
    test_starvation();
    test_store();
    test_timeout();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
